// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream link (AXI-stream subset) between the UART and the command controller.
interface uart_cmd_ctrl_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// ASCII command interpreter between UART RX and TX: echoes every byte, loads the
// LED register from "Lhhhh<CR>", reports {btn,sw} on "S<CR>", answers "?" on errors.
module uart_cmd_ctrl #(
   parameter int LED_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   uart_cmd_ctrl_if.slave       s_axis,
   uart_cmd_ctrl_if.master      m_axis,
   input  logic [3:0]           sw,
   input  logic [3:0]           btn,
   output logic [LED_WIDTH-1:0] led,
   output logic [7:0]           err_count
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HEX  = 3'd1;
   localparam logic [2:0] ST_CR_L = 3'd2;
   localparam logic [2:0] ST_CR_S = 3'd3;
   localparam logic [2:0] ST_RESP = 3'd4;

   localparam logic [1:0] RS_OK   = 2'd0;
   localparam logic [1:0] RS_ERR  = 2'd1;
   localparam logic [1:0] RS_STAT = 2'd2;

   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   logic                 run_q, run_d;
   logic [2:0]           state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [15:0]          opnd_q, opnd_d;
   logic [7:0]           snap_q, snap_d;
   logic [1:0]           rsel_q, rsel_d;
   logic [2:0]           idx_q, idx_d;
   logic [LED_WIDTH-1:0] led_q, led_d;
   logic [7:0]           err_q, err_d;
   logic [7:0]           tdata_q, tdata_d;
   logic                 tvalid_q, tvalid_d;
   logic                 s_ready;
   logic                 accept;
   logic                 bad_cmd;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   // Letters A-F / a-f carry 1..6 in their low nibble.
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   function automatic logic [2:0] resp_len(input logic [1:0] sel);
      return (sel == RS_STAT) ? 3'd4 : 3'd3;
   endfunction

   function automatic logic [7:0] resp_byte(input logic [1:0] sel, input logic [2:0] idx,
                                            input logic [7:0] snap);
      logic [7:0] b;
      if (sel == RS_STAT) begin
         case (idx)
            3'd0:    b = hex_char(snap[7:4]);
            3'd1:    b = hex_char(snap[3:0]);
            3'd2:    b = CH_CR;
            default: b = CH_LF;
         endcase
      end else begin
         case (idx)
            3'd0:    b = (sel == RS_OK) ? 8'h4B : 8'h3F;
            3'd1:    b = CH_CR;
            default: b = CH_LF;
         endcase
      end
      return b;
   endfunction

   assign s_ready       = run_q && !tvalid_q && (state_q != ST_RESP);
   assign accept        = s_axis.tvalid && s_ready;
   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign led           = led_q;
   assign err_count     = err_q;

   always_comb begin
      run_d    = 1'b1;
      state_d  = state_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      snap_d   = snap_q;
      rsel_d   = rsel_q;
      idx_d    = idx_q;
      led_d    = led_q;
      err_d    = err_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      bad_cmd  = 1'b0;

      if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

      if (accept) begin
         tdata_d  = s_axis.tdata;
         tvalid_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (s_axis.tdata == 8'h4C || s_axis.tdata == 8'h6C) begin
                  state_d = ST_HEX;
                  cnt_d   = 2'd0;
                  opnd_d  = 16'h0000;
               end else if (s_axis.tdata == 8'h53 || s_axis.tdata == 8'h73) begin
                  state_d = ST_CR_S;
               end else if (s_axis.tdata != CH_CR && s_axis.tdata != CH_LF) begin
                  bad_cmd = 1'b1;
               end
            end
            ST_HEX: begin
               if (is_hex(s_axis.tdata)) begin
                  opnd_d = {opnd_q[11:0], hex_val(s_axis.tdata)};
                  cnt_d  = cnt_q + 2'd1;
                  if (cnt_q == 2'd3) state_d = ST_CR_L;
               end else begin
                  bad_cmd = 1'b1;
               end
            end
            ST_CR_L: begin
               if (s_axis.tdata == CH_CR) begin
                  led_d   = opnd_q[LED_WIDTH-1:0];
                  rsel_d  = RS_OK;
                  idx_d   = 3'd0;
                  state_d = ST_RESP;
               end else begin
                  bad_cmd = 1'b1;
               end
            end
            ST_CR_S: begin
               if (s_axis.tdata == CH_CR) begin
                  snap_d  = {btn, sw};
                  rsel_d  = RS_STAT;
                  idx_d   = 3'd0;
                  state_d = ST_RESP;
               end else begin
                  bad_cmd = 1'b1;
               end
            end
            default: bad_cmd = 1'b1;
         endcase
         if (bad_cmd) begin
            rsel_d  = RS_ERR;
            idx_d   = 3'd0;
            err_d   = sat_inc(err_q);
            state_d = ST_RESP;
         end
      end else if (state_q == ST_RESP && (!tvalid_q || m_axis.tready)) begin
         // Output slot is free: either present the next byte or, once all are sent, leave.
         if (idx_q == resp_len(rsel_q)) begin
            state_d = ST_IDLE;
         end else begin
            tdata_d  = resp_byte(rsel_q, idx_q, snap_q);
            tvalid_d = 1'b1;
            idx_d    = idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q    <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= 2'd0;
         opnd_q   <= 16'h0000;
         snap_q   <= 8'h00;
         rsel_q   <= RS_OK;
         idx_q    <= 3'd0;
         led_q    <= '0;
         err_q    <= 8'h00;
         tdata_q  <= 8'h00;
         tvalid_q <= 1'b0;
      end else begin
         run_q    <= run_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         snap_q   <= snap_d;
         rsel_q   <= rsel_d;
         idx_q    <= idx_d;
         led_q    <= led_d;
         err_q    <= err_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected output bytes are queued as stimulus is
// sent and compared by a monitor as each byte transfers on the master stream.
module tb_uart_cmd_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  sw, btn;
   logic [15:0] led;
   logic [7:0]  err_count;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];

   uart_cmd_ctrl_if s_if();
   uart_cmd_ctrl_if m_if();

   uart_cmd_ctrl #(.LED_WIDTH(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_axis    (s_if.slave),
      .m_axis    (m_if.master),
      .sw        (sw),
      .btn       (btn),
      .led       (led),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // Transfers happen at the next posedge; inputs only change just after posedges.
   always @(negedge clk) begin
      if (reset_n && m_if.tvalid && m_if.tready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_byte: got unexpected 0x%02h, required nothing", m_if.tdata);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (m_if.tdata !== e) begin
               errors++;
               $display("FAIL out_byte: got 0x%02h, required 0x%02h", m_if.tdata, e);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      s_if.tdata  = b;
      s_if.tvalid = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
      while (!s_if.tready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: s_axis_tready stayed 0, required 1 for byte 0x%02h", b);
      end
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic exp_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic exp_crlf();
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_if.tvalid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || m_if.tvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: %0d bytes outstanding, tvalid %b, required 0 and 0",
                  name, exp_q.size(), m_if.tvalid);
      end
   endtask

   task automatic wait_for_out(input logic [7:0] b);
      int t;
      t = 0;
      while (!(m_if.tvalid && m_if.tdata == b) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      checks++;
      if (t >= 100) begin
         errors++;
         $display("FAIL wait_out: byte 0x%02h never presented, tdata 0x%02h", b, m_if.tdata);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata = 8'h00;
      m_if.tready = 1'b1;
      sw = 4'h0;
      btn = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (led !== 16'h0000 || err_count !== 8'h00 || m_if.tvalid !== 1'b0 ||
          m_if.tdata !== 8'h00 || s_if.tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: led %h err %h tvalid %b tdata %h tready %b, required all 0",
                  led, err_count, m_if.tvalid, m_if.tdata, s_if.tready);
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s_if.tready !== 1'b1) begin
         errors++;
         $display("FAIL run_flag: s_axis_tready %b, required 1", s_if.tready);
      end
   endtask

   task automatic test_load();
      send_str("L0A5F");
      send_byte(8'h0D);
      exp_str("K");
      exp_crlf();
      wait_drain("load");
      checks++;
      if (led !== 16'h0A5F || err_count !== 8'h00) begin
         errors++;
         $display("FAIL load_led: led %h err %h, required 0a5f 00", led, err_count);
      end
   endtask

   task automatic test_status();
      sw = 4'h3;
      btn = 4'h8;
      send_str("S");
      send_byte(8'h0D);
      sw = 4'hF;
      exp_str("83");
      exp_crlf();
      wait_drain("status");
      checks++;
      if (led !== 16'h0A5F || err_count !== 8'h00) begin
         errors++;
         $display("FAIL status_side: led %h err %h, required 0a5f 00", led, err_count);
      end
   endtask

   task automatic test_error_and_stall();
      send_str("L12G");
      exp_str("?");
      exp_crlf();
      wait_drain("error");
      checks++;
      if (err_count !== 8'h01 || led !== 16'h0A5F) begin
         errors++;
         $display("FAIL error_count: err %h led %h, required 01 0a5f", err_count, led);
      end
      send_str("l00ff");
      send_byte(8'h0D);
      exp_str("K");
      exp_crlf();
      wait_for_out(8'h4B);
      m_if.tready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'h4B || s_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: tvalid %b tdata %h s_tready %b, required 1 4b 0",
                     m_if.tvalid, m_if.tdata, s_if.tready);
         end
      end
      @(posedge clk);
      #1;
      m_if.tready = 1'b1;
      wait_drain("stall");
      checks++;
      if (led !== 16'h00FF || err_count !== 8'h01) begin
         errors++;
         $display("FAIL stall_led: led %h err %h, required 00ff 01", led, err_count);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         send_byte(8'h58);
         exp_str("?");
         exp_crlf();
      end
      wait_drain("saturate");
      checks++;
      if (err_count !== 8'hFF || led !== 16'h00FF) begin
         errors++;
         $display("FAIL saturate: err %h led %h, required ff 00ff", err_count, led);
      end
   endtask

   task automatic test_reset_mid_resp();
      sw = 4'h5;
      btn = 4'hA;
      send_str("S");
      send_byte(8'h0D);
      exp_str("A5");
      exp_crlf();
      wait_for_out(8'h41);
      m_if.tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (m_if.tvalid !== 1'b0 || led !== 16'h0000 || err_count !== 8'h00 ||
          s_if.tready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: tvalid %b led %h err %h s_tready %b, required 0 0000 00 0",
                  m_if.tvalid, led, err_count, s_if.tready);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      checks++;
      if (s_if.tready !== 1'b0) begin
         errors++;
         $display("FAIL release_ready_early: s_tready %b, required 0", s_if.tready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (s_if.tready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: s_tready %b, required 1", s_if.tready);
      end
      m_if.tready = 1'b1;
      sw = 4'hC;
      btn = 4'h1;
      send_str("s");
      send_byte(8'h0D);
      exp_str("1C");
      exp_crlf();
      wait_drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_load();
      test_status();
      test_error_and_stall();
      test_saturate();
      test_reset_mid_resp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
